demux1to2_stream: RTL and testbench
===================================

DEMUX1TO2_STREAM -- requirements
Module: demux1to2_stream

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every data port.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_data  input  WIDTH  source beat payload.
REQ-005 in_valid  input  1  source beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 sel  input  1  destination when alt_en=0: 0 -> channel A, 1 -> channel B; sampled with each accepted beat.
REQ-008 alt_en  input  1  1 = alternate A,B,A,... ignoring sel.
REQ-009 a_data / b_data  output  WIDTH  channel A / B payload, registered.
REQ-010 a_valid / b_valid  output  1  channel A / B holds a beat, registered.
REQ-011 a_ready / b_ready  input  1  channel A / B consumer accepts.
REQ-012 a_count / b_count  output  8  beats delivered on channel A / B, wrap 255 -> 0.

Function
REQ-013 Transfer rule on every port: beat moves only in a cycle where valid and ready are both 1.
REQ-014 Target channel T = toggle when alt_en=1, else sel.
REQ-015 Each channel has a one-entry output register; channel X is "free" when X_valid=0 or X_ready=1.
REQ-016 in_ready = ~rst and (T=A ? A free : B free); combinational, no dependence on in_valid.
REQ-017 Accepted beat loads in_data into the T channel register and sets T_valid=1 at the next edge; latency one cycle, in to out.
REQ-018 Non-target channel register unchanged by an input acceptance.
REQ-019 Output handshake on X with no new load into X: X_valid clears at next edge; X_data holds last value.
REQ-020 Output handshake and new load on X in the same cycle: X_data takes new beat, X_valid stays 1 (full throughput, one beat per cycle per channel).
REQ-021 X_valid=1 and X_ready=0: X_data and X_valid held stable until handshake.
REQ-022 Toggle state: flips on each accepted beat while alt_en=1; forced to 0 (A) while alt_en=0, so alternation always starts on A.
REQ-023 alt_en or sel change while source blocked: T and in_ready re-evaluate same cycle; no beat lost or duplicated.
REQ-024 X_count increments by 1 on each output handshake on X; 255 + 1 = 0.
REQ-025 Both channels may complete output handshakes in the same cycle; both counters update independently.
REQ-026 in_valid=0: no register or toggle change except output drains and counts.

Reset
REQ-027 rst=1 at a rising edge: a_valid=b_valid=0, a_data=b_data=0, a_count=b_count=0, toggle=0.
REQ-028 in_ready=0 throughout any cycle with rst=1; beats presented during reset are discarded.
REQ-029 Reset mid-operation discards buffered beats; counters do not count them.
REQ-030 First acceptance possible in the first cycle with rst=0.

Verification
REQ-031 Reset: rst=1 two cycles, in_valid=1 -> in_ready=0, all valids 0, counts 0, data 0.
REQ-032 Fixed route: alt_en=0, sel=1, in_data=0x5A, b_ready=1 -> b_data=0x5A, b_valid=1 next cycle, b_count=1 one cycle later, a_valid stays 0.
REQ-033 Backpressure: sel=0, a_ready=0, beats 0x11 then 0x22 -> a_data=0x11 held, in_ready=0 for 0x22; raise a_ready -> 0x22 accepted same cycle, a_data=0x22 next.
REQ-034 Alternation: alt_en=1, sel=1, ready=1, beats 0x01..0x04 back-to-back -> A gets 0x01,0x03; B gets 0x02,0x04; a_count=b_count=2.
REQ-035 Wrap: 256 beats to A, a_ready=1 -> a_count=0 after last handshake; 257th -> 1.
REQ-036 Reset mid-stream: a_valid=1, b_valid=1, rst=1 one cycle -> both valids 0, counts 0, toggle restarts at A.

Source files
------------

// File: rtl/demux1to2_stream.sv
// rtl/demux1to2_stream.sv - one-to-two stream demux with fixed or alternating routing
// Each output channel is a one-entry register; delivered beats are counted per channel.
module demux1to2_stream #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_sel,
    input  logic             i_alt_en,
    output logic [WIDTH-1:0] o_a_data,
    output logic             o_a_valid,
    input  logic             i_a_ready,
    output logic [WIDTH-1:0] o_b_data,
    output logic             o_b_valid,
    input  logic             i_b_ready,
    output logic [7:0]       o_a_count,
    output logic [7:0]       o_b_count
);

    logic [WIDTH-1:0] r_a_data;
    logic [WIDTH-1:0] r_b_data;
    logic             r_a_valid;
    logic             r_b_valid;
    logic [7:0]       r_a_count;
    logic [7:0]       r_b_count;
    logic             r_toggle;

    logic w_target;
    logic w_a_free;
    logic w_b_free;
    logic w_accept;
    logic w_load_a;
    logic w_load_b;

    // Target: 0 selects channel A, 1 selects channel B.
    assign w_target   = i_alt_en ? r_toggle : i_sel;
    assign w_a_free   = ~r_a_valid | i_a_ready;
    assign w_b_free   = ~r_b_valid | i_b_ready;
    assign o_in_ready = ~i_rst & (w_target ? w_b_free : w_a_free);
    assign w_accept   = i_in_valid & o_in_ready;
    assign w_load_a   = w_accept & ~w_target;
    assign w_load_b   = w_accept & w_target;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_data  <= '0;
            r_b_data  <= '0;
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_a_count <= 8'd0;
            r_b_count <= 8'd0;
            r_toggle  <= 1'b0;
        end else begin
            if (w_load_a) begin
                r_a_data  <= i_in_data;
                r_a_valid <= 1'b1;
            end else if (i_a_ready) begin
                r_a_valid <= 1'b0;
            end

            if (w_load_b) begin
                r_b_data  <= i_in_data;
                r_b_valid <= 1'b1;
            end else if (i_b_ready) begin
                r_b_valid <= 1'b0;
            end

            if (r_a_valid && i_a_ready) begin
                r_a_count <= r_a_count + 8'd1;
            end
            if (r_b_valid && i_b_ready) begin
                r_b_count <= r_b_count + 8'd1;
            end

            // Held at A whenever alternation is off so it always restarts on A.
            if (!i_alt_en) begin
                r_toggle <= 1'b0;
            end else if (w_accept) begin
                r_toggle <= ~r_toggle;
            end
        end
    end

    assign o_a_data  = r_a_data;
    assign o_b_data  = r_b_data;
    assign o_a_valid = r_a_valid;
    assign o_b_valid = r_b_valid;
    assign o_a_count = r_a_count;
    assign o_b_count = r_b_count;

endmodule

// File: tb/tb_demux1to2_stream.sv
// tb/tb_demux1to2_stream.sv - directed vector bench for demux1to2_stream
module tb_demux1to2_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       sel;
    logic       alt_en;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] a_count;
    logic [7:0] b_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux1to2_stream #(.WIDTH(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in_data  (in_data),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_sel      (sel),
        .i_alt_en   (alt_en),
        .o_a_data   (a_data),
        .o_a_valid  (a_valid),
        .i_a_ready  (a_ready),
        .o_b_data   (b_data),
        .o_b_valid  (b_valid),
        .i_b_ready  (b_ready),
        .o_a_count  (a_count),
        .o_b_count  (b_count)
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] d;
        logic       sel;
        logic       alt;
        logic       ar;
        logic       br;
        logic       e_ir;
        logic       e_av;
        logic [7:0] e_ad;
        logic       e_bv;
        logic [7:0] e_bd;
        logic [7:0] e_ac;
        logic [7:0] e_bc;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic r, logic iv, logic [7:0] d, logic s, logic al,
                                logic ar, logic br, logic ir, logic av, logic [7:0] ad,
                                logic bv, logic [7:0] bd, logic [7:0] ac, logic [7:0] bc);
        vec_t v;
        v.rst = r; v.iv = iv; v.d = d; v.sel = s; v.alt = al; v.ar = ar; v.br = br;
        v.e_ir = ir; v.e_av = av; v.e_ad = ad; v.e_bv = bv; v.e_bd = bd;
        v.e_ac = ac; v.e_bc = bc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [7:0] d, input logic s,
                         input logic al, input logic ar, input logic br);
        rst = r; in_valid = iv; in_data = d; sel = s; alt_en = al;
        a_ready = ar; b_ready = br;
    endtask

    initial begin
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        //            rst iv  data   sel alt ar  br   ir  av  ad     bv  bd     ac     bc
        vecs[0]  = mk(1, 1, 8'hFF, 0, 0, 0, 0,  0, 0, 8'h00, 0, 8'h00, 8'd0, 8'd0);
        vecs[1]  = mk(1, 1, 8'hFF, 0, 0, 0, 0,  0, 0, 8'h00, 0, 8'h00, 8'd0, 8'd0);
        vecs[2]  = mk(0, 1, 8'h5A, 1, 0, 0, 1,  1, 0, 8'h00, 1, 8'h5A, 8'd0, 8'd0);
        vecs[3]  = mk(0, 0, 8'h00, 1, 0, 0, 1,  1, 0, 8'h00, 0, 8'h5A, 8'd0, 8'd1);
        vecs[4]  = mk(0, 1, 8'h11, 0, 0, 0, 0,  1, 1, 8'h11, 0, 8'h5A, 8'd0, 8'd1);
        vecs[5]  = mk(0, 1, 8'h22, 0, 0, 0, 0,  0, 1, 8'h11, 0, 8'h5A, 8'd0, 8'd1);
        vecs[6]  = mk(0, 1, 8'h22, 0, 0, 1, 0,  1, 1, 8'h22, 0, 8'h5A, 8'd1, 8'd1);
        vecs[7]  = mk(0, 0, 8'h00, 0, 0, 1, 0,  1, 0, 8'h22, 0, 8'h5A, 8'd2, 8'd1);
        vecs[8]  = mk(0, 1, 8'h01, 1, 1, 1, 1,  1, 1, 8'h01, 0, 8'h5A, 8'd2, 8'd1);
        vecs[9]  = mk(0, 1, 8'h02, 1, 1, 1, 1,  1, 0, 8'h01, 1, 8'h02, 8'd3, 8'd1);
        vecs[10] = mk(0, 1, 8'h03, 1, 1, 1, 1,  1, 1, 8'h03, 0, 8'h02, 8'd3, 8'd2);
        vecs[11] = mk(0, 1, 8'h04, 1, 1, 1, 1,  1, 0, 8'h03, 1, 8'h04, 8'd4, 8'd2);
        vecs[12] = mk(0, 0, 8'h00, 1, 1, 1, 1,  1, 0, 8'h03, 0, 8'h04, 8'd4, 8'd3);
        vecs[13] = mk(0, 1, 8'hA1, 1, 1, 0, 0,  1, 1, 8'hA1, 0, 8'h04, 8'd4, 8'd3);
        vecs[14] = mk(0, 1, 8'hB2, 1, 1, 0, 0,  1, 1, 8'hA1, 1, 8'hB2, 8'd4, 8'd3);
        vecs[15] = mk(1, 1, 8'hC3, 1, 1, 0, 0,  0, 0, 8'h00, 0, 8'h00, 8'd0, 8'd0);
        vecs[16] = mk(0, 1, 8'hD4, 1, 1, 0, 0,  1, 1, 8'hD4, 0, 8'h00, 8'd0, 8'd0);
        vecs[17] = mk(0, 1, 8'hE5, 0, 0, 0, 0,  0, 1, 8'hD4, 0, 8'h00, 8'd0, 8'd0);
        vecs[18] = mk(0, 1, 8'hE5, 1, 0, 0, 0,  1, 1, 8'hD4, 1, 8'hE5, 8'd0, 8'd0);
        vecs[19] = mk(0, 0, 8'h00, 1, 0, 1, 1,  1, 0, 8'hD4, 0, 8'hE5, 8'd1, 8'd1);
        vecs[20] = mk(0, 1, 8'hF6, 1, 1, 1, 1,  1, 1, 8'hF6, 0, 8'hE5, 8'd1, 8'd1);
        vecs[21] = mk(0, 0, 8'h00, 1, 1, 1, 1,  1, 0, 8'hF6, 0, 8'hE5, 8'd2, 8'd1);

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].sel, vecs[i].alt,
                  vecs[i].ar, vecs[i].br);
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d a_valid", i), 32'(a_valid), 32'(vecs[i].e_av));
            chk($sformatf("v%0d a_data", i),  32'(a_data),  32'(vecs[i].e_ad));
            chk($sformatf("v%0d b_valid", i), 32'(b_valid), 32'(vecs[i].e_bv));
            chk($sformatf("v%0d b_data", i),  32'(b_data),  32'(vecs[i].e_bd));
            chk($sformatf("v%0d a_count", i), 32'(a_count), 32'(vecs[i].e_ac));
            chk($sformatf("v%0d b_count", i), 32'(b_count), 32'(vecs[i].e_bc));
        end

        // Counter wrap: 256 back-to-back beats to A, then one more.
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            chk("wrap in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        chk("wrap a_valid full", 32'(a_valid), 32'd1);
        chk("wrap a_data last", 32'(a_data), 32'hFF);
        chk("wrap a_count 255", 32'(a_count), 32'd255);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("wrap a_count 0", 32'(a_count), 32'd0);
        chk("wrap a_valid drained", 32'(a_valid), 32'd0);
        chk("wrap b_count", 32'(b_count), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("wrap 257th data", 32'(a_data), 32'h77);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("wrap a_count 1", 32'(a_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
